// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA fixed-point update datapath:
// default word format, controller state encoding and saturation helper.
package fastica_pkg;

  localparam int FASTICA_DW   = 16;
  localparam int FASTICA_FRAC = 12;

  // Q-format unity (1.0) at the default word format.
  localparam logic signed [FASTICA_DW-1:0] ONE = FASTICA_DW'(1 << FASTICA_FRAC);

  // Clamp limits for a signed FASTICA_DW-bit word, held at 64 bits for comparisons.
  localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (FASTICA_DW - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_LO = -(64'sd1 <<< (FASTICA_DW - 1));

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Saturate a wide signed intermediate to one signed data word.
  function automatic logic signed [FASTICA_DW-1:0] sat_dw(input logic signed [63:0] x);
    if (x > SAT_HI) begin
      return SAT_HI[FASTICA_DW-1:0];
    end else if (x < SAT_LO) begin
      return SAT_LO[FASTICA_DW-1:0];
    end else begin
      return x[FASTICA_DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fastica_update_unit_if.sv
// Bus between the FastICA update unit, its controller, the sample memory
// and the weight register file. The unit is the slave side.
interface fastica_update_unit_if
  import fastica_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = FASTICA_DW,
  parameter int LOG2T = 7
);
  localparam int AW = $clog2(N);

  logic                go_fast;
  logic                fast_busy;
  logic                z_rd;
  logic [LOG2T-1:0]    z_addr;
  logic [N*DW-1:0]     z_data;
  logic [AW-1:0]       w_row_addr;
  logic [N*DW-1:0]     w_row_data;
  logic                w_we;
  logic [AW-1:0]       w_wr_addr;
  logic [N*DW-1:0]     w_wr_data;

  modport slave (
    input  go_fast, z_data, w_row_data,
    output fast_busy, z_rd, z_addr, w_row_addr, w_we, w_wr_addr, w_wr_data
  );

  modport master (
    output go_fast, z_data, w_row_data,
    input  fast_busy, z_rd, z_addr, w_row_addr, w_we, w_wr_addr, w_wr_data
  );
endinterface

// File: rtl/fastica_cube_dot.sv
// Combinational projection y = w.z followed by the cubic nonlinearity y^3.
// Every rescale is an arithmetic (floor) shift followed by saturation.
module fastica_cube_dot
  import fastica_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = FASTICA_DW,
  parameter int FRAC = FASTICA_FRAC
) (
  input  logic        [N*DW-1:0] i_w_cur,
  input  logic        [N*DW-1:0] i_z,
  output logic signed [DW-1:0]   o_y3
);

  logic signed [63:0]   w_sum;
  logic signed [DW-1:0] w_y;
  logic signed [DW-1:0] w_yy;

  // Full-precision dot product, shifted and saturated once, then cubed in two saturating steps.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N; j++) begin
      w_sum = w_sum + 64'(signed'(i_w_cur[j*DW +: DW])) * 64'(signed'(i_z[j*DW +: DW]));
    end
    w_y  = sat_dw(w_sum >>> FRAC);
    w_yy = sat_dw((64'(w_y) * 64'(w_y)) >>> FRAC);
    o_y3 = sat_dw((64'(w_yy) * 64'(w_y)) >>> FRAC);
  end

endmodule

// File: rtl/fastica_update_unit.sv
// One FastICA iteration with the cubic nonlinearity over all N weight rows:
// w_i <- E{z (w_i.z)^3} - 3 w_i, with the mean taken over T = 2^LOG2T samples.
module fastica_update_unit
  import fastica_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = FASTICA_DW,
  parameter int FRAC  = FASTICA_FRAC,
  parameter int LOG2T = 7
) (
  input  logic                   clk_fast,
  input  logic                   rst_n,
  fastica_update_unit_if.slave   bus
);

  localparam int AW = $clog2(N);
  localparam int AW_ACC = DW + LOG2T;

  state_e                    r_state;
  state_e                    w_next;
  logic [AW-1:0]             r_i;
  logic [LOG2T-1:0]          r_t;
  logic                      r_drain;
  logic [N*DW-1:0]           r_w_cur;
  logic signed [AW_ACC-1:0]  r_acc [N];
  logic                      r_vld_p0;
  logic                      r_vld_p1;
  logic [N*DW-1:0]           r_z_p1;
  logic signed [DW-1:0]      r_y3_p1;
  logic signed [DW-1:0]      w_y3;
  logic [N*DW-1:0]           w_wr_data;

  fastica_cube_dot #(
    .N    (N),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_cube_dot (
    .i_w_cur (r_w_cur),
    .i_z     (bus.z_data),
    .o_y3    (w_y3)
  );

  // Next-state logic; dropping go_fast anywhere outside IDLE abandons the iteration.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.go_fast) w_next = ST_LOAD_W;
      ST_LOAD_W: w_next = ST_RUN;
      ST_RUN:    if (&r_t) w_next = ST_DRAIN;
      ST_DRAIN:  if (r_drain) w_next = ST_WRITE;
      ST_WRITE:  w_next = (r_i == AW'(N - 1)) ? ST_DONE : ST_LOAD_W;
      ST_DONE:   w_next = ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
    if (!bus.go_fast && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  // Control state: FSM, row/sample counters and pipeline valid bits.
  always_ff @(posedge clk_fast) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_t      <= '0;
      r_drain  <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_vld_p0 <= (r_state == ST_RUN);
      r_vld_p1 <= r_vld_p0;
      case (r_state)
        ST_IDLE:   r_i <= '0;
        ST_LOAD_W: begin
          r_t     <= '0;
          r_drain <= 1'b0;
        end
        ST_RUN:    r_t <= r_t + 1'b1;
        ST_DRAIN:  r_drain <= 1'b1;
        ST_WRITE:  r_i <= r_i + 1'b1;
        default:   ;
      endcase
    end
  end

  // Row latch and stage-1 pipeline register; data path carries no reset.
  always_ff @(posedge clk_fast) begin
    if (r_state == ST_LOAD_W) r_w_cur <= bus.w_row_data;
    // stage p0 -> p1: sample has arrived, register z and y^3
    if (r_vld_p0) begin
      r_z_p1  <= bus.z_data;
      r_y3_p1 <= w_y3;
    end
  end

  // Stage-2 accumulation of sat(z_j * y^3); cleared at the start of every row.
  always_ff @(posedge clk_fast) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) r_acc[j] <= '0;
    end else if (r_state == ST_LOAD_W) begin
      for (int j = 0; j < N; j++) r_acc[j] <= '0;
    end else if (r_vld_p1) begin
      // stage p1 -> accumulators
      for (int j = 0; j < N; j++) begin
        r_acc[j] <= r_acc[j] + AW_ACC'(sat_dw(
                      (64'(signed'(r_z_p1[j*DW +: DW])) * 64'(r_y3_p1)) >>> FRAC));
      end
    end
  end

  // New row value: mean of the accumulators minus 3*w, driven only while writing.
  always_comb begin
    w_wr_data = '0;
    for (int j = 0; j < N; j++) begin
      logic signed [DW+2:0] w_avg;
      logic signed [DW+2:0] w_w1;
      logic signed [DW+2:0] w_diff;
      w_avg  = (DW+3)'(r_acc[j] >>> LOG2T);
      w_w1   = (DW+3)'(signed'(r_w_cur[j*DW +: DW]));
      w_diff = w_avg - (w_w1 + (w_w1 <<< 1));
      if (r_state == ST_WRITE) w_wr_data[j*DW +: DW] = sat_dw(64'(w_diff));
    end
  end

  // Busy rises combinationally with go_fast so the controller never sees a stale idle.
  assign bus.fast_busy  = (bus.go_fast && (r_state == ST_IDLE)) ||
                          ((r_state != ST_IDLE) && (r_state != ST_DONE));
  assign bus.z_rd       = (r_state == ST_RUN);
  assign bus.z_addr     = r_t;
  assign bus.w_row_addr = r_i;
  assign bus.w_we       = (r_state == ST_WRITE) && bus.go_fast;
  assign bus.w_wr_addr  = r_i;
  assign bus.w_wr_data  = w_wr_data;

endmodule

// File: doc/fastica_update_unit.md
# fastica_update_unit

Responder to the FastICA top controller's `go_fast`/`fast_busy` handshake. The block performs one fixed-point FastICA iteration with the cubic nonlinearity over all N weight rows: w_i ← E{z·(w_iᵀz)³} − 3·w_i. It reads whitened samples from the sample memory, reads and writes the weight register file, and holds `fast_busy` high until every row has been written back.

## Interface
- `N`, 4: number of components (rows of W, length of z)
- `DW`, 16: word width, signed two's complement
- `FRAC`, 12: fractional bits (Q4.12 at defaults)
- `LOG2T`, 7: log2 of the sample count T (T = 128)

- `clk_fast` in 1: clock; all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `go_fast` in 1: level request from the controller
- `fast_busy` out 1: high while the iteration is in progress
- `z_rd` out 1: sample read strobe
- `z_addr` out LOG2T: sample index
- `z_data` in N·DW: packed sample vector, element j at [j·DW +: DW]; valid the cycle after `z_rd`
- `w_row_addr` out clog2(N): weight read row
- `w_row_data` in N·DW: combinational read of row `w_row_addr`
- `w_we` out 1: weight write strobe, one cycle
- `w_wr_addr` out clog2(N): weight write row
- `w_wr_data` out N·DW: new row value

## Operation
- States:
  - IDLE: go_fast → LOAD_W
  - LOAD_W: latch `w_row_data` into `w_cur`, clear the N accumulators, t=0 → RUN
  - RUN: issue `z_rd` for t = 0..T−1, one per cycle; after t=T−1 → DRAIN
  - DRAIN: 2 cycles, pipeline empties → WRITE
  - WRITE: `w_we`=1 for row i; i=N−1 → DONE, otherwise i++ → LOAD_W
  - DONE: wait for go_fast low → IDLE
- `fast_busy` = (go_fast & state==IDLE) | (state ∉ {IDLE, DONE}). It is high in the same cycle go_fast rises, so the controller never samples a false not-busy.
- Pipeline stage 1 (registered on z_data arrival):
  - y = sat_DW(Σ_j w_cur_j·z_j >>> FRAC); the full-precision sum is shifted and saturated once.
  - y3 = sat(sat(y·y>>>FRAC)·y>>>FRAC).
  - y3 and z are registered.
- Pipeline stage 2: acc_j += sat_DW(z_j·y3 >>> FRAC). Accumulator width is DW+LOG2T, with no overflow possible.
- WRITE: w_wr_data_j = sat_DW((acc_j >>> LOG2T) − 3·w_cur_j). The subtraction is evaluated in DW+3 bits.
- All shifts are arithmetic with truncation toward −∞. Saturation clamps to [−2^(DW−1), 2^(DW−1)−1].
- Row i's update uses only `w_cur`, latched before any write of that row. Rows already written are not re-read in this iteration.
- go_fast low in any non-IDLE state:
  - Next state is IDLE; no further `w_we`.
  - Rows already written keep their new values.
  - Accumulators are cleared on the next LOAD_W.
- rst_n low: state=IDLE, i=0, t=0, accumulators and pipeline valid bits are 0.

## Timing
- Reset values: fast_busy=0, z_rd=0, z_addr=0, w_we=0, w_wr_addr=0, w_wr_data=0, w_row_addr=0.
- Per row: 1 (LOAD_W) + T (RUN) + 2 (DRAIN) + 1 (WRITE) = T+4 cycles.
- Total `fast_busy` high: 1 (IDLE cycle with go_fast) + N·(T+4). At defaults this is 529 cycles.
- `w_row_addr` = i during LOAD_W.
- `z_addr` = t during RUN, and `z_rd` is high exactly T cycles per row.
- `w_we` asserts in the last cycle of each row.
- The last write is in the cycle before DONE. `fast_busy` falls on entry to DONE.

## Structure
- Shared package `fastica_pkg`:
  - DW/FRAC defaults
  - the state enum
  - a `sat_dw` function
  - the Q-format constant ONE = 1<<FRAC
- Sub-module `fastica_cube_dot`: combinational w·z dot product plus the y³ stage. It is instantiated once, feeding the stage-1 register.

## Test plan
- Reset/handshake:
  - With rst_n=0 for 3 cycles, all outputs are 0.
  - After go_fast rises, fast_busy is 1 in that same cycle and stays high for exactly 529 cycles at defaults.
- Zero samples: z≡0, W=I (diagonal 0x1000) → each row i is written with 0xD000 at element i and 0 elsewhere, with four `w_we` pulses in order i=0..3.
- Unit sample: z≡(0x1000,0,0,0) for all t, W=I:
  - row 0 → (0xE000,0,0,0)
  - rows 1..3 → 0xD000 on the diagonal
- Saturation: z≡(0x2000)×4, every row (0x1000)×4. y, y³ and the products all saturate to 0x7FFF, so every written element is 0x4FFF.
- Abort: drop go_fast at busy cycle 200 (row 1 in RUN):
  - No `w_we` after the drop.
  - Row 0 is updated; rows 1..3 are unchanged.
  - fast_busy is 0 from the next cycle.
  - A fresh go_fast then completes normally.
- DONE hold: keep go_fast high for 10 cycles after completion. fast_busy stays 0 with no extra reads or writes, and the block returns to IDLE one cycle after go_fast falls.
